irq_pending_ctrl: RTL and testbench

Interrupt request controller directly upstream of the CPU's priority `encoder`. It captures 2**op_L request lines into a pending register, applies a mask, and arbitrates highest-index-wins. It presents a registered one-hot `grant` that drives the encoder's `Din`, and holds it stable through an irq/ack/eoi handshake with the control unit.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_prio_onehot.sv | 21 ++
 rtl/irq_pending_ctrl.sv | 105 ++++++++++
 tb/tb_irq_pending_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and FSM encoding for the interrupt pending controller.
package irq_pkg;

  // Default index width; source count is 2**op_L.
  localparam int OP_L_DEF = 4;

  // Handshake FSM with the control unit.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } irq_state_e;

  // Every source comes out of reset masked; replicate to N bits at use.
  localparam logic MASK_RST_BIT = 1'b1;

endpackage

// File: rtl/irq_prio_onehot.sv
// irq_prio_onehot: combinational highest-index-wins one-hot selector.
// A zero request vector yields a zero grant.
module irq_prio_onehot #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Ascending scan; a later (higher) hit replaces any earlier one.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: captures request lines into a pending register, masks
// them, picks the highest index and holds a registered one-hot grant through
// the irq/ack/eoi handshake.
// Build option: define IRQ_EDGE_DETECT_EN for rising-edge capture with
// ack-driven clearing; otherwise pending simply follows irq_src (level mode).
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int op_L = OP_L_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [(2**op_L)-1:0] irq_src,
  input  logic                 mask_we,
  input  logic [(2**op_L)-1:0] mask_din,
  input  logic                 ack,
  input  logic                 eoi,
  output logic [(2**op_L)-1:0] mask_q,
  output logic [(2**op_L)-1:0] pending,
  output logic                 irq,
  output logic [(2**op_L)-1:0] grant
);

  localparam int N = 2**op_L;

  irq_state_e   state;
  logic [N-1:0] eligible;
  logic [N-1:0] winner;

  assign eligible = pending & ~mask_q;

  irq_prio_onehot #(.N(N)) u_prio (
    .req (eligible),
    .gnt (winner)
  );

`ifdef IRQ_EDGE_DETECT_EN
  logic [N-1:0] src_prev;
  logic [N-1:0] clr;

  // Only an accepted ack (in REQ) clears, and only the frozen winner bit.
  assign clr = grant & {N{(state == REQ) && ack}};

  // Rising-edge capture; a new edge outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev <= '0;
      pending  <= '0;
    end else begin
      src_prev <= irq_src;
      pending  <= (pending & ~clr) | (irq_src & ~src_prev);
    end
  end
`else
  // Level mode: pending mirrors the request lines, ack has no effect on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= irq_src;
  end
`endif

  // Mask register; a write is seen by arbitration the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask_q <= {N{MASK_RST_BIT}};
    else if (mask_we) mask_q <= mask_din;
  end

  // Handshake FSM; grant is loaded only from IDLE so it never changes
  // while the CPU owns the vector (no preemption).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      irq   <= 1'b0;
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            grant <= winner;
            irq   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            irq   <= 1'b0;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl: directed vectors against a behavioural model of the
// interrupt controller, plus hand-computed literal expectations.
module tb_irq_pending_ctrl;

  localparam int N = 16;
`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_din = '0;
  logic         ack = 1'b0;
  logic         eoi = 1'b0;
  logic [N-1:0] mask_q;
  logic [N-1:0] pending;
  logic         irq;
  logic [N-1:0] grant;

  int nvec = 0;
  int nmis = 0;

  // model state: phase 0 idle, 1 requesting, 2 in service; gidx -1 = none
  logic [N-1:0] m_pend, m_mask, m_prev;
  int           m_phase, m_gidx;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.op_L(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .mask_we  (mask_we),
    .mask_din (mask_din),
    .ack      (ack),
    .eoi      (eoi),
    .mask_q   (mask_q),
    .pending  (pending),
    .irq      (irq),
    .grant    (grant)
  );

  function automatic int top_idx(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] bit_of(input int idx);
    logic [N-1:0] r;
    r = '0;
    if (idx >= 0) r[idx] = 1'b1;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset;
    m_pend  = '0;
    m_mask  = '1;
    m_prev  = '0;
    m_phase = 0;
    m_gidx  = -1;
  endtask

  // One clock of the controller's rules, using pre-edge inputs and state.
  task automatic model_step;
    logic [N-1:0] elig;
    logic [N-1:0] clr;
    elig = m_pend & ~m_mask;
    clr  = (m_phase == 1 && ack) ? bit_of(m_gidx) : '0;
    if (EDGE) m_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
    else      m_pend = irq_src;
    m_prev = irq_src;
    if (mask_we) m_mask = mask_din;
    case (m_phase)
      0: if (elig != '0) begin m_gidx = top_idx(elig); m_phase = 1; end
      1: if (ack) m_phase = 2;
      2: if (eoi) begin m_phase = 0; m_gidx = -1; end
      default: ;
    endcase
  endtask

  task automatic check_all;
    cmp("irq", N'(irq), N'(m_phase == 1));
    cmp("grant", grant, bit_of(m_gidx));
    cmp("pending", pending, m_pend);
    cmp("mask_q", mask_q, m_mask);
    cmp("grant_onehot", N'($countones(grant) <= 1), N'(1));
  endtask

  // Advance one clock, update the model, then compare on the falling edge.
  task automatic cyc;
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    cmp("rst_irq", N'(irq), '0);
    cmp("rst_grant", grant, '0);
    cmp("rst_pending", pending, '0);
    cmp("rst_mask", mask_q, 16'hFFFF);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // unmask everything, single pulse on source 5
    mask_we = 1'b1; mask_din = 16'h0000; cyc(); mask_we = 1'b0;
    cmp("mask_zero", mask_q, 16'h0000);
    irq_src = 16'h0020; cyc();
    cmp("p5_pending", pending, 16'h0020);
    irq_src = 16'h0000; cyc();
    cmp("p5_irq", N'(irq), N'(1));
    cmp("p5_grant", grant, 16'h0020);
    cmp("p5_pending_held", pending, EDGE ? 16'h0020 : 16'h0000);
    ack = 1'b1; cyc(); ack = 1'b0;
    cmp("p5_ack_irq", N'(irq), '0);
    cmp("p5_ack_pending", pending, 16'h0000);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cmp("p5_eoi_grant", grant, 16'h0000);

    // sources 3 and 12 together: 12 first, 3 after one idle cycle
    irq_src = 16'h1008; cyc();
    irq_src = 16'h0000; cyc();
    cmp("dual_grant12", grant, 16'h1000);
    ack = 1'b1; cyc(); ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cmp("dual_idle", grant, 16'h0000);
    cyc();
    cmp("dual_grant3", grant, EDGE ? 16'h0008 : 16'h0000);
    ack = 1'b1; cyc(); ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;

    // mask bit 12 while 3 and 12 arrive: 3 wins, 12 parks until unmasked
    mask_we = 1'b1; mask_din = 16'h1000; irq_src = 16'h1008; cyc();
    mask_we = 1'b0; irq_src = 16'h0000;
    cmp("mask_q_1000", mask_q, 16'h1000);
    cyc();
    cmp("mask_grant3", grant, 16'h0008);
    ack = 1'b1; cyc(); ack = 1'b0;
    cmp("mask_pending12", pending, EDGE ? 16'h1000 : 16'h0000);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc(); cyc();
    cmp("mask_parked_grant", grant, 16'h0000);
    cmp("mask_parked_pend", pending, EDGE ? 16'h1000 : 16'h0000);
    mask_we = 1'b1; mask_din = 16'h0000; cyc(); mask_we = 1'b0;
    cyc();
    cmp("unmask_grant12", grant, EDGE ? 16'h1000 : 16'h0000);

    // new edge on 12 in the same cycle as its ack: set wins, re-granted
    irq_src = 16'h1000; ack = 1'b1; cyc(); ack = 1'b0;
    cmp("setwin_pending", pending, 16'h1000);
    cmp("setwin_irq", N'(irq), '0);
    irq_src = 16'h0000; eoi = 1'b1; cyc(); eoi = 1'b0;
    cmp("setwin_eoi", grant, EDGE ? 16'h0000 : 16'h1000);
    cyc();
    cmp("setwin_regrant", grant, 16'h1000);
    ack = 1'b1; cyc(); ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;

    // async reset in the middle of servicing source 5
    irq_src = 16'h0020; cyc();
    irq_src = 16'h0000; cyc();
    cmp("svc_grant5", grant, 16'h0020);
    ack = 1'b1; cyc(); ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp("arst_irq", N'(irq), '0);
    cmp("arst_grant", grant, '0);
    cmp("arst_pending", pending, '0);
    cmp("arst_mask", mask_q, 16'hFFFF);
    model_reset();
    cyc();
    rst = 1'b0;
    cyc();

    // source 7 held high through ack and eoi
    mask_we = 1'b1; mask_din = 16'h0000; cyc(); mask_we = 1'b0;
    irq_src = 16'h0080; cyc(); cyc();
    cmp("hold_grant7", grant, 16'h0080);
    ack = 1'b1; cyc(); ack = 1'b0;
    cmp("hold_pending", pending, EDGE ? 16'h0000 : 16'h0080);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cmp("hold_eoi", grant, 16'h0000);
    cyc();
    cmp("hold_regrant", grant, EDGE ? 16'h0000 : 16'h0080);
    irq_src = 16'h0000;
    ack = 1'b1; cyc(); ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc();

    // ack+eoi together in REQ, higher source 15 arriving mid-handshake
    irq_src = 16'h0200; cyc();
    irq_src = 16'h8200; cyc();
    cmp("nopre_grant9", grant, 16'h0200);
    ack = 1'b1; eoi = 1'b1; cyc(); ack = 1'b0; eoi = 1'b0;
    cmp("ackeoi_grant", grant, 16'h0200);
    cmp("ackeoi_irq", N'(irq), '0);
    irq_src = 16'h0000; cyc();
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cmp("ackeoi_release", grant, 16'h0000);
    cyc();
    cmp("late15_grant", grant, EDGE ? 16'h8000 : 16'h0000);
    ack = 1'b1; cyc(); ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
